// File: rtl/xadc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xadc_pkg
//  Description : Shared types and constants for the XADC auxiliary-channel
//                sampler (state encoding, DRP data field, channel count).
//  Revision    : 1.0 - initial release
// ============================================================================
package xadc_pkg;

  // Sampler sequencing states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    WAIT_EOC = 3'd2,
    DRP_REQ  = 3'd3,
    DRP_WAIT = 3'd4
  } state_t;

  // The 12-bit conversion result sits in drp_do[15:4]
  localparam int DRP_DATA_LSB = 4;
  localparam int SAMPLE_W     = 12;
  localparam int AUX_CHANNELS = 4;

  // External analog mux select: one-hot (1<<ch) or binary {2'b00,ch}
  function automatic logic [3:0] mux_encode(input logic [1:0] ch, input logic onehot);
    logic [3:0] sel;
    if (onehot) begin
      sel = 4'b0001 << ch;
    end else begin
      sel = {2'b00, ch};
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xadc_aux_sampler_accum.sv
`default_nettype none
// ============================================================================
//  Module      : aux_avg_accum
//  Description : Accumulates 2^AVG_LOG2 12-bit samples and presents the
//                truncated average together with the sample that completes
//                the block. Time-shared across channels by the sampler.
//  Revision    : 1.0 - initial release
// ============================================================================
module aux_avg_accum
  import xadc_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic                S_AXI_ACLK,
  input  logic                Local_Reset,
  input  logic                i_clear,
  input  logic                i_add_en,
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic                o_last,
  output logic [SAMPLE_W-1:0] o_average
);

  localparam int c_acc_w = SAMPLE_W + AVG_LOG2;
  localparam int c_cnt_w = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((1 << AVG_LOG2) - 1);

  logic [c_acc_w-1:0] r_acc;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_acc_w-1:0] w_sum;

  // The incoming sample is folded in combinationally so the average is
  // available on the same edge that accepts the final sample.
  assign w_sum     = r_acc + c_acc_w'(i_sample);
  assign o_last    = (r_cnt == c_cnt_last);
  assign o_average = w_sum[AVG_LOG2 +: SAMPLE_W];

  // Accumulator and count; a completed block or an abort restarts from zero
  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clear || (i_add_en && o_last)) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_add_en) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/xadc_aux_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : xadc_aux_sampler
//  Description : Round-robin sampler for four XADC auxiliary inputs behind an
//                external 4:1 analog mux. Settles the mux, waits for EOC,
//                reads the DRP, averages 2^AVG_LOG2 conversions per channel
//                and holds the results on MEASURED_AUX0..3.
//  Revision    : 1.0 - initial release
// ============================================================================
module xadc_aux_sampler
  import xadc_pkg::*;
#(
  parameter int         AVG_LOG2      = 2,
  parameter int         SETTLE_CYCLES = 64,
  parameter int         DRP_TIMEOUT   = 255,
  parameter logic [6:0] AUX_ADDR_BASE = 7'h10
) (
  input  logic        S_AXI_ACLK,
  input  logic        Local_Reset,
  input  logic        enable,
  input  logic        onehot_mux,
  input  logic        eoc,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  input  logic        drp_drdy,
  input  logic [15:0] drp_do,
  output logic [3:0]  mux_sel,
  output logic [11:0] MEASURED_AUX0,
  output logic [11:0] MEASURED_AUX1,
  output logic [11:0] MEASURED_AUX2,
  output logic [11:0] MEASURED_AUX3,
  output logic        sample_valid,
  output logic        drp_timeout_err
);

  localparam int c_settle_w = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int c_tmo_w    = (DRP_TIMEOUT < 2) ? 1 : $clog2(DRP_TIMEOUT + 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_den;
  logic [c_settle_w-1:0] r_settle_cnt;
  logic [c_tmo_w-1:0]    r_tmo_cnt;
  logic [1:0]            r_ch;
  logic [6:0]            r_daddr;
  logic [SAMPLE_W-1:0]   r_meas [AUX_CHANNELS];
  logic                  r_valid;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_tmo;
  logic                  w_abort;
  logic                  w_last;
  logic                  w_done;
  logic [SAMPLE_W-1:0]   w_sample;
  logic [SAMPLE_W-1:0]   w_average;
  logic                  w_unused_lsbs;

  assign w_sample      = drp_do[15:DRP_DATA_LSB];
  assign w_unused_lsbs = ^drp_do[DRP_DATA_LSB-1:0];

  // Only the single in-flight read can deliver data; drdy elsewhere is ignored
  assign w_accept = (r_state == DRP_WAIT) && drp_drdy;
  // Counter ran out with no drdy: the read is abandoned
  assign w_tmo    = (r_state == DRP_WAIT) && !drp_drdy && (r_tmo_cnt == '0);
  // Disabling is only honoured between reads
  assign w_abort  = ((r_state == SETTLE) || (r_state == WAIT_EOC)) && !enable;
  assign w_done   = w_accept && w_last;

  aux_avg_accum #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .S_AXI_ACLK  (S_AXI_ACLK),
    .Local_Reset (Local_Reset),
    .i_clear     (w_tmo || w_abort),
    .i_add_en    (w_accept),
    .i_sample    (w_sample),
    .o_last      (w_last),
    .o_average   (w_average)
  );

  // State register
  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and the one-cycle DRP enable
  always_comb begin
    w_state_nxt = r_state;
    w_den       = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (r_settle_cnt == '0) begin
          w_state_nxt = WAIT_EOC;
        end
      end
      WAIT_EOC: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (eoc) begin
          w_state_nxt = DRP_REQ;
        end
      end
      DRP_REQ: begin
        w_den       = 1'b1;
        w_state_nxt = DRP_WAIT;
      end
      DRP_WAIT: begin
        if (drp_drdy) begin
          w_state_nxt = w_last ? SETTLE : WAIT_EOC;
        end else if (r_tmo_cnt == '0) begin
          w_state_nxt = SETTLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Settle and DRP timeout counters, loaded on entry to their wait states
  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      r_settle_cnt <= '0;
      r_tmo_cnt    <= '0;
    end else begin
      if ((w_state_nxt == SETTLE) && (r_state != SETTLE)) begin
        r_settle_cnt <= c_settle_w'(SETTLE_CYCLES);
      end else if ((r_state == SETTLE) && (r_settle_cnt != '0)) begin
        r_settle_cnt <= r_settle_cnt - 1'b1;
      end
      // Loading one less than the limit lets drdy arrive up to DRP_TIMEOUT
      // cycles after the den pulse
      if (r_state == DRP_REQ) begin
        r_tmo_cnt <= c_tmo_w'(DRP_TIMEOUT - 1);
      end else if ((r_state == DRP_WAIT) && (r_tmo_cnt != '0)) begin
        r_tmo_cnt <= r_tmo_cnt - 1'b1;
      end
    end
  end

  // Channel pointer, DRP address latch, results, update pulse and sticky error
  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      r_ch    <= '0;
      r_daddr <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < AUX_CHANNELS; i++) begin
        r_meas[i] <= '0;
      end
    end else begin
      r_valid <= w_done;
      if ((r_state == WAIT_EOC) && (w_state_nxt == DRP_REQ)) begin
        r_daddr <= AUX_ADDR_BASE + 7'(r_ch);
      end
      if (w_done) begin
        r_meas[r_ch] <= w_average;
      end
      if (w_done || w_tmo) begin
        r_ch <= r_ch + 2'd1;
      end
      if (w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end

  assign drp_den         = w_den;
  assign drp_dwe         = 1'b0;
  assign drp_daddr       = r_daddr;
  assign mux_sel         = mux_encode(r_ch, onehot_mux);
  assign MEASURED_AUX0   = r_meas[0];
  assign MEASURED_AUX1   = r_meas[1];
  assign MEASURED_AUX2   = r_meas[2];
  assign MEASURED_AUX3   = r_meas[3];
  assign sample_valid    = r_valid;
  assign drp_timeout_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_xadc_aux_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xadc_aux_sampler
//  Description : Directed self-checking bench for xadc_aux_sampler with
//                default parameters (AVG_LOG2=2, SETTLE_CYCLES=64,
//                DRP_TIMEOUT=255, AUX_ADDR_BASE=7'h10).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xadc_aux_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        onehot_mux;
  logic        eoc;
  logic        drp_drdy;
  logic [15:0] drp_do;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic [3:0]  mux_sel;
  logic [11:0] aux0, aux1, aux2, aux3;
  logic        sample_valid;
  logic        drp_timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xadc_aux_sampler dut (
    .S_AXI_ACLK      (clk),
    .Local_Reset     (rst),
    .enable          (enable),
    .onehot_mux      (onehot_mux),
    .eoc             (eoc),
    .drp_den         (drp_den),
    .drp_dwe         (drp_dwe),
    .drp_daddr       (drp_daddr),
    .drp_drdy        (drp_drdy),
    .drp_do          (drp_do),
    .mux_sel         (mux_sel),
    .MEASURED_AUX0   (aux0),
    .MEASURED_AUX1   (aux1),
    .MEASURED_AUX2   (aux2),
    .MEASURED_AUX3   (aux3),
    .sample_valid    (sample_valid),
    .drp_timeout_err (drp_timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold eoc high until the DUT issues drp_den (bounded), then drop eoc
  task automatic wait_den(input logic [6:0] exp_addr);
    int n;
    n   = 0;
    eoc = 1'b1;
    while (drp_den !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    eoc = 1'b0;
    chk("den_seen", drp_den, 1'b1);
    chk("daddr", drp_daddr, exp_addr);
  endtask

  // One full conversion: drdy with data lat cycles after den is seen
  task automatic conv(input logic [15:0] data, input int lat, input logic [6:0] exp_addr);
    wait_den(exp_addr);
    repeat (lat) tick();
    chk("daddr_hold", drp_daddr, exp_addr);
    drp_drdy = 1'b1;
    drp_do   = data;
    tick();
    drp_drdy = 1'b0;
    drp_do   = 16'hFFFF;
  endtask

  // Pulse eoc every cycle and require that no drp_den appears
  task automatic no_den(input int cycles, input string tag);
    bit any;
    any = 1'b0;
    eoc = 1'b1;
    repeat (cycles) begin
      tick();
      if (drp_den !== 1'b0) any = 1'b1;
    end
    eoc = 1'b0;
    chk(tag, any, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    onehot_mux = 1'b0;
    eoc        = 1'b0;
    drp_drdy   = 1'b0;
    drp_do     = 16'h0000;
    repeat (3) tick();

    // Reset state
    chk("rst_den", drp_den, 1'b0);
    chk("rst_dwe", drp_dwe, 1'b0);
    chk("rst_daddr", drp_daddr, 7'h00);
    chk("rst_mux_bin", mux_sel, 4'b0000);
    chk("rst_aux0", aux0, 12'h000);
    chk("rst_aux3", aux3, 12'h000);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_err", drp_timeout_err, 1'b0);
    onehot_mux = 1'b1;
    #1;
    chk("rst_mux_onehot", mux_sel, 4'b0001);
    onehot_mux = 1'b0;

    // Channel 0: four reads of 0x8000, drdy 3 cycles after den
    rst    = 1'b0;
    enable = 1'b1;
    tick();
    conv(16'h8000, 3, 7'h10);
    conv(16'h8000, 3, 7'h10);
    conv(16'h8000, 3, 7'h10);
    chk("ch0_partial_valid", sample_valid, 1'b0);
    conv(16'h8000, 3, 7'h10);
    chk("ch0_valid", sample_valid, 1'b1);
    chk("ch0_aux0", aux0, 12'h800);
    chk("ch0_mux_bin", mux_sel, 4'b0001);
    onehot_mux = 1'b1;
    #1;
    chk("ch0_mux_onehot", mux_sel, 4'b0010);
    onehot_mux = 1'b0;
    tick();
    chk("ch0_valid_one_cycle", sample_valid, 1'b0);

    // Channel 1: drdy withheld until the read times out
    wait_den(7'h11);
    repeat (255) tick();
    chk("tmo_not_yet", drp_timeout_err, 1'b0);
    tick();
    chk("tmo_err_set", drp_timeout_err, 1'b1);
    chk("tmo_aux1_kept", aux1, 12'h000);
    chk("tmo_valid", sample_valid, 1'b0);
    chk("tmo_ch_adv", mux_sel, 4'b0010);

    // Channel 2: samples 1,2,3,5 -> 11>>2 = 2
    conv(16'h0010, 1, 7'h12);
    conv(16'h0020, 2, 7'h12);
    conv(16'h0030, 1, 7'h12);
    conv(16'h0050, 4, 7'h12);
    chk("ch2_valid", sample_valid, 1'b1);
    chk("ch2_aux2", aux2, 12'h002);
    chk("ch2_aux0_kept", aux0, 12'h800);

    // Channel 3: full-scale samples
    conv(16'hFFF0, 1, 7'h13);
    conv(16'hFFF0, 1, 7'h13);
    conv(16'hFFF0, 1, 7'h13);
    conv(16'hFFF0, 1, 7'h13);
    chk("ch3_aux3", aux3, 12'hFFF);
    chk("wrap_mux", mux_sel, 4'b0000);
    chk("err_sticky", drp_timeout_err, 1'b1);

    // Wrap: eoc during settle is ignored, then channel 0 again
    no_den(60, "settle_eoc_ignored");
    conv(16'h1230, 2, 7'h10);

    // Disable while a read is in flight: it completes, then idle
    wait_den(7'h10);
    tick();
    enable = 1'b0;
    tick();
    tick();
    drp_drdy = 1'b1;
    drp_do   = 16'h5670;
    tick();
    drp_drdy = 1'b0;
    drp_do   = 16'hFFFF;
    chk("dis_valid", sample_valid, 1'b0);
    no_den(20, "dis_no_den");
    chk("dis_ch_kept", mux_sel, 4'b0000);

    // Re-enable: earlier partial sum on channel 0 must be gone
    enable = 1'b1;
    conv(16'h4000, 1, 7'h10);
    conv(16'h4000, 1, 7'h10);
    chk("reen_valid_after2", sample_valid, 1'b0);
    conv(16'h4000, 1, 7'h10);
    chk("reen_valid_after3", sample_valid, 1'b0);
    conv(16'h4000, 1, 7'h10);
    chk("reen_valid", sample_valid, 1'b1);
    chk("reen_aux0", aux0, 12'h400);

    // Reset in the middle of a channel-1 read, then a late drdy
    wait_den(7'h11);
    tick();
    rst = 1'b1;
    #1;
    chk("async_rst_aux0", aux0, 12'h000);
    tick();
    rst    = 1'b0;
    enable = 1'b0;
    drp_drdy = 1'b1;
    drp_do   = 16'h8000;
    tick();
    drp_drdy = 1'b0;
    drp_do   = 16'hFFFF;
    tick();
    chk("late_drdy_valid", sample_valid, 1'b0);
    chk("late_drdy_aux0", aux0, 12'h000);
    chk("late_drdy_aux1", aux1, 12'h000);
    chk("late_drdy_aux2", aux2, 12'h000);
    chk("late_drdy_aux3", aux3, 12'h000);
    chk("rst_err_clear", drp_timeout_err, 1'b0);
    no_den(20, "rst_no_den");
    chk("rst_ch0", mux_sel, 4'b0000);
    enable = 1'b1;
    conv(16'h8000, 1, 7'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
